// File: rtl/keccak_digest_reader_if.sv
// Valid/ready byte link from the digest reader toward the UART transmitter.
interface keccak_digest_reader_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/keccak_digest_reader.sv
// Captures the top DIGEST_BITS of the Keccak state and streams them as bytes.
// Define HEX_ASCII_EN to send lowercase ASCII hex characters plus a trailing newline.
module keccak_digest_reader #(
    parameter int DIGEST_BITS = 512
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1599:0]          state_in,
    input  logic                   state_ready,
    input  logic                   hash_done,
    input  logic                   clear,
    keccak_digest_reader_if.master tx,
    output logic                   busy,
    output logic                   done
);
    localparam int NBYTES = DIGEST_BITS / 8;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

`ifdef HEX_ASCII_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, NEWLINE = 2'd2} state_t;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] code;
        if (nib < 4'd10) begin
            code = 8'h30 + {4'h0, nib};
        end else begin
            code = 8'h57 + {4'h0, nib};
        end
        return code;
    endfunction

    logic nib_r, nib_next_s;
`else
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
`endif

    state_t                 state_r, state_next_s;
    logic [DIGEST_BITS-1:0] shift_r, shift_next_s, shift_adv_s;
    logic [CW-1:0]          count_r, count_next_s;
    logic                   armed_r, armed_next_s;
    logic [7:0]             data_r, data_next_s;
    logic                   valid_r, valid_next_s;
    logic                   busy_r, busy_next_s;
    logic                   done_r, done_next_s;
    logic                   trigger_s, xfer_s;

    assign trigger_s     = state_ready & hash_done;
    assign xfer_s        = valid_r & tx.byte_ready;
    assign tx.byte_data  = data_r;
    assign tx.byte_valid = valid_r;
    assign busy          = busy_r;
    assign done          = done_r;

    // Only the top DIGEST_BITS of the state are ever captured.
    generate
        if (DIGEST_BITS < 1600) begin : g_low_bits
            logic unused_state_s;
            assign unused_state_s = ^state_in[1599-DIGEST_BITS:0];
        end
    endgenerate

    // State, digest copy and output registers; reset returns to idle and re-arms.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            shift_r <= {DIGEST_BITS{1'b0}};
            count_r <= {CW{1'b0}};
            armed_r <= 1'b1;
            data_r  <= 8'h00;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef HEX_ASCII_EN
            nib_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_next_s;
            shift_r <= shift_next_s;
            count_r <= count_next_s;
            armed_r <= armed_next_s;
            data_r  <= data_next_s;
            valid_r <= valid_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
`ifdef HEX_ASCII_EN
            nib_r   <= nib_next_s;
`endif
        end
    end

    // Next-state logic: capture, per-transfer advance, end of stream and abort.
    always_comb begin
        state_next_s = state_r;
        shift_next_s = shift_r;
        count_next_s = count_r;
        data_next_s  = data_r;
        valid_next_s = valid_r;
        busy_next_s  = busy_r;
        done_next_s  = 1'b0;
        shift_adv_s  = shift_r << 4'd8;
`ifdef HEX_ASCII_EN
        nib_next_s   = nib_r;
`endif
        // A trigger level held after completion must fall before another capture.
        if (trigger_s) begin
            armed_next_s = armed_r;
        end else begin
            armed_next_s = 1'b1;
        end

        if (clear) begin
            state_next_s = IDLE;
            count_next_s = {CW{1'b0}};
            valid_next_s = 1'b0;
            busy_next_s  = 1'b0;
`ifdef HEX_ASCII_EN
            nib_next_s   = 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (trigger_s && armed_r) begin
                        shift_next_s = state_in[1599 -: DIGEST_BITS];
                        armed_next_s = 1'b0;
                        count_next_s = {CW{1'b0}};
                        valid_next_s = 1'b1;
                        busy_next_s  = 1'b1;
                        state_next_s = SEND;
`ifdef HEX_ASCII_EN
                        nib_next_s   = 1'b0;
                        data_next_s  = hex_char(state_in[1599 -: 4]);
`else
                        data_next_s  = state_in[1599 -: 8];
`endif
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                SEND: begin
                    if (xfer_s) begin
`ifdef HEX_ASCII_EN
                        if (!nib_r) begin
                            nib_next_s  = 1'b1;
                            data_next_s = hex_char(shift_r[DIGEST_BITS-5 -: 4]);
                        end else if (count_r == LAST_IDX) begin
                            nib_next_s   = 1'b0;
                            data_next_s  = 8'h0A;
                            state_next_s = NEWLINE;
                        end else begin
                            nib_next_s   = 1'b0;
                            shift_next_s = shift_adv_s;
                            count_next_s = count_r + CW'(1);
                            data_next_s  = hex_char(shift_adv_s[DIGEST_BITS-1 -: 4]);
                        end
`else
                        if (count_r == LAST_IDX) begin
                            state_next_s = IDLE;
                            count_next_s = {CW{1'b0}};
                            valid_next_s = 1'b0;
                            busy_next_s  = 1'b0;
                            done_next_s  = 1'b1;
                        end else begin
                            shift_next_s = shift_adv_s;
                            count_next_s = count_r + CW'(1);
                            data_next_s  = shift_adv_s[DIGEST_BITS-1 -: 8];
                        end
`endif
                    end else begin
                        state_next_s = SEND;
                    end
                end
`ifdef HEX_ASCII_EN
                NEWLINE: begin
                    if (xfer_s) begin
                        state_next_s = IDLE;
                        count_next_s = {CW{1'b0}};
                        valid_next_s = 1'b0;
                        busy_next_s  = 1'b0;
                        done_next_s  = 1'b1;
                    end else begin
                        state_next_s = NEWLINE;
                    end
                end
`endif
                default: begin
                    state_next_s = IDLE;
                    valid_next_s = 1'b0;
                    busy_next_s  = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_keccak_digest_reader.sv
// Self-checking bench for keccak_digest_reader: vector table, random backpressure, corner sequences.
`timescale 1ns/1ps
module tb_keccak_digest_reader;
    localparam int DIGEST_BITS = 512;
    localparam int NBYTES = DIGEST_BITS / 8;
`ifdef HEX_ASCII_EN
    localparam bit HEX = 1'b1;
    localparam int NXFER = 2 * NBYTES + 1;
`else
    localparam bit HEX = 1'b0;
    localparam int NXFER = NBYTES;
`endif

    logic          clk = 1'b0;
    logic          reset, clear, state_ready, hash_done;
    logic [1599:0] state_in;
    logic          busy, done;

    keccak_digest_reader_if bus();

    keccak_digest_reader #(.DIGEST_BITS(DIGEST_BITS)) dut (
        .clk(clk), .reset(reset), .state_in(state_in), .state_ready(state_ready),
        .hash_done(hash_done), .clear(clear), .tx(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = -10, last_xfer_cyc = -10;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_abort = 1'b1;
    logic [7:0] prev_data = 8'h00;

    typedef struct {
        int kind;        // 0 ramp, 1 random, 2 A5/0F/zeros, 3 all ones
        int stall_pct;
        int trig_cycles;
        bit clobber;
        int exp_xfers;
        int exp_done;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records transfers and done pulses, checks the hold rule.
    always @(negedge clk) begin
        if (prev_valid && !prev_ready && !prev_abort) begin
            check("hold_valid", {31'd0, bus.byte_valid}, 32'd1);
            check("hold_data", {24'd0, bus.byte_data}, {24'd0, prev_data});
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_after_last", cyc - last_xfer_cyc, 32'd1);
            check("done_on_boundary", got_q.size() % NXFER, 32'd0);
            check("done_valid_low", {31'd0, bus.byte_valid}, 32'd0);
        end
        if (bus.byte_valid && bus.byte_ready && !clear && !reset) begin
            got_q.push_back(bus.byte_data);
            last_xfer_cyc = cyc;
        end
        prev_valid = bus.byte_valid;
        prev_ready = bus.byte_ready;
        prev_abort = clear | reset;
        prev_data  = bus.byte_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_trig(input logic v);
        state_ready = v;
        hash_done   = v;
    endtask

    function automatic logic [1599:0] make_state(input int kind);
        logic [1599:0] s;
        for (int i = 0; i < 200; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (i < NBYTES) begin
                case (kind)
                    0: b = 8'(i);
                    2: b = (i == 0) ? 8'hA5 : ((i == 1) ? 8'h0F : 8'h00);
                    3: b = 8'hFF;
                    default: ;
                endcase
            end
            s[1599 - 8*i -: 8] = b;
        end
        return s;
    endfunction

    // Reference: top digest bytes MSB first, or their lowercase hex text plus newline.
    function automatic void build_exp(input logic [1599:0] s);
        string hx;
        logic [7:0] b;
        hx = "0123456789abcdef";
        for (int i = 0; i < NBYTES; i++) begin
            b = s[1599 - 8*i -: 8];
            if (HEX) begin
                exp_q.push_back(8'(hx[b[7:4]]));
                exp_q.push_back(8'(hx[b[3:0]]));
            end else begin
                exp_q.push_back(b);
            end
        end
        if (HEX) exp_q.push_back(8'h0A);
    endfunction

    task automatic compare_stream(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(name, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    endtask

    task automatic run_until_done(input int target, input int stall_pct);
        int k;
        int r;
        k = 0;
        while (done_cnt < target && k < 4000) begin
            r = int'($urandom_range(99));
            bus.byte_ready = (r >= stall_pct);
            tick();
            k++;
        end
        check("stream_timeout", {31'd0, done_cnt >= target}, 32'd1);
        bus.byte_ready = 1'b1;
    endtask

    task automatic run_case(input vec_t v, input int idx);
        logic [1599:0] s;
        int trig_left, k, start, r;
        logic [7:0] hdr [4];
        got_q.delete(); exp_q.delete(); done_cnt = 0;
        s = make_state(v.kind);
        build_exp(s);
        state_in = s;
        set_trig(1'b1);
        r = int'($urandom_range(99));
        bus.byte_ready = (r >= v.stall_pct);
        @(negedge clk);
        check("pre_capture_valid", {31'd0, bus.byte_valid}, 32'd0);
        tick();
        if (v.clobber) state_in = {1600{1'b1}};
        trig_left = v.trig_cycles - 1;
        if (trig_left == 0) set_trig(1'b0);
        @(negedge clk);
        start = cyc;
        check("latency_valid", {31'd0, bus.byte_valid}, 32'd1);
        check("latency_busy", {31'd0, busy}, 32'd1);
        check("first_byte", {24'd0, bus.byte_data}, {24'd0, exp_q[0]});
        k = 0;
        while ((done_cnt < 1 || trig_left > 0) && k < 4000) begin
            tick();
            k++;
            if (trig_left > 0) begin
                trig_left--;
                if (trig_left == 0) set_trig(1'b0);
            end
            r = int'($urandom_range(99));
            bus.byte_ready = (r >= v.stall_pct);
        end
        check("case_timeout", {31'd0, k < 4000}, 32'd1);
        bus.byte_ready = 1'b1;
        repeat (10) tick();
        compare_stream($sformatf("vec%0d", idx));
        check("vec_xfers", got_q.size(), v.exp_xfers);
        check("vec_done", done_cnt, v.exp_done);
        check("vec_idle_busy", {31'd0, busy}, 32'd0);
        check("vec_idle_valid", {31'd0, bus.byte_valid}, 32'd0);
        if (v.stall_pct == 0 && v.exp_done == 1)
            check("back_to_back", done_cyc - start, NXFER);
        if (v.kind == 2) begin
            if (HEX) hdr = '{8'h61, 8'h35, 8'h30, 8'h66};
            else     hdr = '{8'hA5, 8'h0F, 8'h00, 8'h00};
            for (int i = 0; i < 4; i++)
                check("pattern_head", {24'd0, got_q[i]}, {24'd0, hdr[i]});
        end
    endtask

    vec_t vecs[7];

    initial begin
        logic [1599:0] s;
        int k;
        vecs[0] = '{0,  0,   1, 1'b0, NXFER, 1};   // ramp, free-running
        vecs[1] = '{0,  0,   1, 1'b1, NXFER, 1};   // state changed after capture
        vecs[2] = '{2,  0,   1, 1'b0, NXFER, 1};   // A5 0F 00...
        vecs[3] = '{1, 30,   3, 1'b0, NXFER, 1};
        vecs[4] = '{1, 60,   1, 1'b1, NXFER, 1};
        vecs[5] = '{1,  0, 200, 1'b0, NXFER, 1};   // long trigger level: one stream
        vecs[6] = '{3, 50,   1, 1'b0, NXFER, 1};

        reset = 1'b1; clear = 1'b0; set_trig(1'b0);
        state_in = {1600{1'b0}}; bus.byte_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data", {24'd0, bus.byte_data}, 32'd0);
        check("rst_valid", {31'd0, bus.byte_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_case(vecs[i], i);

        // Backpressure: hold the fourth item for five cycles.
        got_q.delete(); exp_q.delete(); done_cnt = 0;
        s = make_state(0); build_exp(s); state_in = s;
        set_trig(1'b1); bus.byte_ready = 1'b1;
        tick();
        set_trig(1'b0);
        k = 0;
        while (got_q.size() < 3 && k < 100) begin tick(); k++; end
        bus.byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, bus.byte_valid}, 32'd1);
            check("stall_data", {24'd0, bus.byte_data}, {24'd0, exp_q[3]});
        end
        tick();
        run_until_done(1, 0);
        compare_stream("backpressure");

        // Re-arm: long level gives one stream; a one-cycle drop gives exactly one more.
        got_q.delete(); exp_q.delete(); done_cnt = 0;
        s = make_state(0); build_exp(s); state_in = s;
        set_trig(1'b1); bus.byte_ready = 1'b1;
        repeat (200) tick();
        check("rearm_one_done", done_cnt, 32'd1);
        check("rearm_one_count", got_q.size(), NXFER);
        set_trig(1'b0);
        tick();
        set_trig(1'b1);
        tick();
        @(negedge clk);
        check("rearm_valid", {31'd0, bus.byte_valid}, 32'd1);
        check("rearm_first", {24'd0, bus.byte_data}, {24'd0, exp_q[0]});
        build_exp(s);
        tick();
        run_until_done(2, 20);
        compare_stream("rearm");
        set_trig(1'b0);
        repeat (3) tick();

        // clear after the eleventh transfer with the trigger held high.
        got_q.delete(); exp_q.delete(); done_cnt = 0;
        s = make_state(0); build_exp(s); state_in = s;
        set_trig(1'b1); bus.byte_ready = 1'b1;
        k = 0;
        while (got_q.size() < 11 && k < 300) begin tick(); k++; end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        check("clr_valid", {31'd0, bus.byte_valid}, 32'd0);
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_done", {31'd0, done}, 32'd0);
        repeat (20) tick();
        check("clr_no_restart", got_q.size(), 32'd11);
        check("clr_no_done", done_cnt, 32'd0);
        check("clr_idle_valid", {31'd0, bus.byte_valid}, 32'd0);

        // reset mid-stream re-arms, so the held trigger restarts the stream.
        set_trig(1'b0);
        tick();
        set_trig(1'b1);
        got_q.delete();
        k = 0;
        while (got_q.size() < 5 && k < 300) begin tick(); k++; end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rstm_valid", {31'd0, bus.byte_valid}, 32'd0);
        check("rstm_busy", {31'd0, busy}, 32'd0);
        check("rstm_data", {24'd0, bus.byte_data}, 32'd0);
        got_q.delete(); done_cnt = 0;
        @(negedge clk);
        check("rstm_restart", {31'd0, bus.byte_valid}, 32'd1);
        tick();
        run_until_done(1, 25);
        compare_stream("reset_restart");
        set_trig(1'b0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
